// File: rtl/ofm_writeback_sequencer_if.sv
// Row-stream and OFM RAM write-port bundle for ofm_writeback_sequencer.
// master = sequencer side, slave = systolic array / RAM side.
interface ofm_writeback_sequencer_if #(
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned INOUT_WIDTH   = 128,
  parameter int unsigned IFM_SIZE      = 34,
  parameter int unsigned KERNEL_SIZE   = 3,
  parameter int unsigned NO_FILTER     = 16
);
  localparam int unsigned OFM_SIZE = IFM_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned EPB      = INOUT_WIDTH / (2 * DATA_WIDTH);
  localparam int unsigned AW       = $clog2(OFM_SIZE * OFM_SIZE * NO_FILTER);
  localparam int unsigned FW       = (NO_FILTER > 1) ? $clog2(NO_FILTER) : 1;
  localparam int unsigned RW       = SYSTOLIC_SIZE * 2 * DATA_WIDTH;

  logic                   in_valid;
  logic                   in_ready;
  logic [RW-1:0]          in_data;
  logic [FW-1:0]          in_filter;
  logic                   ofm_we;
  logic [AW-1:0]          ofm_addr;
  logic [INOUT_WIDTH-1:0] ofm_wdata;
  logic [EPB-1:0]         ofm_wmask;

  modport master (
    input  in_valid, in_data, in_filter,
    output in_ready, ofm_we, ofm_addr, ofm_wdata, ofm_wmask
  );

  modport slave (
    output in_valid, in_data, in_filter,
    input  in_ready, ofm_we, ofm_addr, ofm_wdata, ofm_wmask
  );
endinterface

// File: rtl/ofm_writeback_sequencer.sv
// Splits systolic result rows into OFM RAM write beats and tracks tile/filter progress.
// Define OFM_RELU_EN to clamp negative output elements to zero on the write path.
module ofm_writeback_sequencer #(
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned INOUT_WIDTH   = 128,
  parameter int unsigned IFM_SIZE      = 34,
  parameter int unsigned KERNEL_SIZE   = 3,
  parameter int unsigned NO_FILTER     = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  ofm_writeback_sequencer_if.master        bus,
  output logic                             tile_done,
  output logic                             busy,
  output logic                             done
);
  localparam int unsigned EW        = 2 * DATA_WIDTH;
  localparam int unsigned OFM_SIZE  = IFM_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned EPB       = INOUT_WIDTH / EW;
  localparam int unsigned BEATS     = SYSTOLIC_SIZE / EPB;
  localparam int unsigned TPL       = (OFM_SIZE + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int unsigned NO_TILING = TPL * OFM_SIZE;
  localparam int unsigned AW        = $clog2(OFM_SIZE * OFM_SIZE * NO_FILTER);
  localparam int unsigned FW        = (NO_FILTER > 1) ? $clog2(NO_FILTER) : 1;
  localparam int unsigned RW        = SYSTOLIC_SIZE * EW;
  localparam int unsigned BW        = $clog2(BEATS + 1);
  localparam int unsigned CW        = $clog2(TPL + 1);
  localparam int unsigned LW        = $clog2(OFM_SIZE + 1);
  localparam int unsigned TW        = $clog2(NO_TILING + 1);
  localparam int unsigned NW        = $clog2(NO_FILTER + 1);

  typedef enum logic [1:0] {StIdle, StRun, StWrite, StDone} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   col_q, col_d;
  logic [LW-1:0]   line_q, line_d;
  logic [TW-1:0]   tile_cnt_q, tile_cnt_d;
  logic [NW-1:0]   row_cnt_q, row_cnt_d;
  logic [RW-1:0]   row_q;
  logic [FW-1:0]   filter_q;
  logic            tile_done_q, tile_done_d;
  logic            load;

  logic [INOUT_WIDTH-1:0] beat_word;
  logic [31:0]            col_base;
  logic                   filter_ok;
  logic [EW-1:0]          elem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      col_q       <= '0;
      line_q      <= '0;
      tile_cnt_q  <= '0;
      row_cnt_q   <= '0;
      row_q       <= '0;
      filter_q    <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      col_q       <= col_d;
      line_q      <= line_d;
      tile_cnt_q  <= tile_cnt_d;
      row_cnt_q   <= row_cnt_d;
      tile_done_q <= tile_done_d;
      if (load) begin
        row_q    <= bus.in_data;
        filter_q <= bus.in_filter;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    col_d       = col_q;
    line_d      = line_q;
    tile_cnt_d  = tile_cnt_q;
    row_cnt_d   = row_cnt_q;
    tile_done_d = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRun;
          beat_d     = '0;
          col_d      = '0;
          line_d     = '0;
          tile_cnt_d = '0;
          row_cnt_d  = '0;
        end
      end
      StRun: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          beat_d  = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (beat_q == BW'(BEATS - 1)) begin
          beat_d  = '0;
          state_d = StRun;
          // Rows are counted, not matched against filter indices.
          if (row_cnt_q == NW'(NO_FILTER - 1)) begin
            row_cnt_d   = '0;
            tile_done_d = 1'b1;
            tile_cnt_d  = tile_cnt_q + TW'(1);
            if (col_q == CW'(TPL - 1)) begin
              col_d  = '0;
              line_d = line_q + LW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            if (tile_cnt_q == TW'(NO_TILING - 1)) state_d = StDone;
          end else begin
            row_cnt_d = row_cnt_q + NW'(1);
          end
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign beat_word = row_q[32'(beat_q) * INOUT_WIDTH +: INOUT_WIDTH];
  // OFM column of this beat's element 0.
  assign col_base  = 32'(col_q) * SYSTOLIC_SIZE + 32'(beat_q) * EPB;
  assign filter_ok = (32'(filter_q) < NO_FILTER);

  always_comb begin
    bus.ofm_we    = 1'b0;
    bus.ofm_addr  = '0;
    bus.ofm_wdata = '0;
    bus.ofm_wmask = '0;
    elem          = '0;
    if (state_q == StWrite) begin
      for (int k = 0; k < EPB; k++) begin
        elem = beat_word[k * EW +: EW];
`ifdef OFM_RELU_EN
        if (elem[EW-1]) elem = '0;
`endif
        bus.ofm_wdata[k * EW +: EW] = elem;
        bus.ofm_wmask[k] = filter_ok && ((col_base + 32'(k)) < OFM_SIZE);
      end
      bus.ofm_addr = AW'(filter_q) * AW'(OFM_SIZE * OFM_SIZE)
                   + AW'(line_q) * AW'(OFM_SIZE)
                   + AW'(col_base);
      // A fully masked beat still occupies its cycle, it just does not strobe.
      bus.ofm_we   = |bus.ofm_wmask;
    end
  end

  assign bus.in_ready = (state_q == StRun);
  assign busy         = (state_q == StRun) || (state_q == StWrite);
  assign done         = (state_q == StDone);
  assign tile_done    = tile_done_q;

endmodule
